ram_bit_wr_ctrl: RTL
====================

Name: ram_bit_wr_ctrl

Overview:
- Write-port controller for the dual-read/single-write bit RAM.
- After reset, and on command, sequences a full clear: every bit is written to 0, one address per clock.
- In normal operation, shares the single write port between two requesters, CPU and I/O scanner, using a round-robin valid/ack handshake.
- Drives the RAM write port (address, data, write enable) directly. Read ports are not touched.

Parameters:
- AWIDTH, 8, bit-address width. Clear covers addresses 0 to 2**AWIDTH-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr_start  in  1  requests a full memory clear; sampled in RUN only.
- busy  out  1  high while in CLEAR.
- clr_done  out  1  one-cycle pulse in the cycle the last address is cleared.
- cpu_wr_req  in  1  CPU write request; held until acked.
- cpu_wr_addr  in  AWIDTH  CPU write address.
- cpu_wr_data  in  1  CPU write bit.
- cpu_wr_ack  out  1  CPU write accepted this cycle.
- io_wr_req  in  1  I/O write request; held until acked.
- io_wr_addr  in  AWIDTH  I/O write address.
- io_wr_data  in  1  I/O write bit.
- io_wr_ack  out  1  I/O write accepted this cycle.
- port_c_address  out  AWIDTH  RAM write address.
- port_c_data  out  1  RAM write data.
- port_c_we  out  1  RAM write enable.

Behaviour:
- States: CLEAR, RUN. Registered state: state, clr_cnt[AWIDTH-1:0], last_grant (0=CPU, 1=IO).
- Reset (rst high at an edge): state<=CLEAR, clr_cnt<=0, last_grant<=IO.
  - While rst is high, all outputs are forced low: busy, clr_done, both acks, port_c_we, port_c_address=0, port_c_data=0.
  - Reset mid-clear or mid-arbitration aborts immediately and the clear restarts from address 0.
- CLEAR:
  - port_c_we=1, port_c_address=clr_cnt, port_c_data=0, busy=1.
  - clr_cnt increments each cycle.
  - When clr_cnt = 2**AWIDTH-1: clr_done=1 that cycle; next state RUN; clr_cnt wraps to 0.
  - First clear after reset release takes exactly 2**AWIDTH cycles (256 at default); busy low from cycle 2**AWIDTH.
  - No acks in CLEAR. Requests stay pending and must be held. clr_start is ignored.
- RUN:
  - busy=0.
  - clr_start=1 takes priority over any request: no ack and no write that cycle; next state CLEAR, clr_cnt=0.
  - Otherwise, arbitration is combinational within the cycle:
    - Only one requester active: grant it.
    - Both active: grant the one not equal to last_grant.
    - On grant: ack=1 for the winner (zero-latency handshake), port_c_we=1, port_c_address/port_c_data = winner's addr/data. The write commits at the same rising edge. last_grant<=winner.
    - No request: port_c_we=0, port_c_address=0, port_c_data=0, last_grant unchanged.
  - Each ack-high cycle is exactly one write. A requester wanting one write deasserts req in the cycle after ack. Req still high after ack counts as a new request.
  - Fairness: under continuous contention, grants strictly alternate; worst-case wait is 1 cycle.
  - Never more than one ack high per cycle. port_c_we high in RUN if and only if exactly one ack is high.
- Reads issued on RAM read ports during CLEAR return stale or zero data. Consumers gate reads on busy=0.

Test Plan:
- Reset release, no requests -> port_c_we=1 for 256 consecutive cycles with addresses 0..255 and data 0; clr_done pulses with address 255; busy falls at cycle 256.
- RUN, cpu_wr_req only, addr 0x12, data 1 -> cpu_wr_ack=1 the same cycle; port_c_we=1, port_c_address=0x12, port_c_data=1; io_wr_ack=0.
- Both requesters held high for 4 cycles (CPU addr 0x01, IO addr 0x80) -> acks CPU, IO, CPU, IO; port_c_address 0x01, 0x80, 0x01, 0x80.
- io_wr_req asserted during CLEAR at cycle 10 and held -> no ack until cycle 256; io_wr_ack=1 at cycle 256 with that address written.
- RUN, clr_start and cpu_wr_req together -> no ack, no CPU write; next cycle busy=1 and port_c_address=0; cpu_wr_ack arrives after clr_done.
- rst pulsed at clr_cnt=100 -> all outputs low during rst; the clear restarts from address 0 and needs 256 more cycles.

Source files
------------

// File: rtl/ram_bit_wr_ctrl.sv
// ============================================================================
// Module   : ram_bit_wr_ctrl
// Brief    : Write-port controller for the dual-read/single-write bit RAM.
//            Clears the whole RAM after reset or on command, then shares the
//            write port between CPU and I/O scanner with round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_bit_wr_ctrl #(
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_start,
    output logic              busy,
    output logic              clr_done,
    input  logic              cpu_wr_req,
    input  logic [AWIDTH-1:0] cpu_wr_addr,
    input  logic              cpu_wr_data,
    output logic              cpu_wr_ack,
    input  logic              io_wr_req,
    input  logic [AWIDTH-1:0] io_wr_addr,
    input  logic              io_wr_data,
    output logic              io_wr_ack,
    output logic [AWIDTH-1:0] port_c_address,
    output logic              port_c_data,
    output logic              port_c_we
);

    localparam logic [0:0]        c_st_clear  = 1'b0;
    localparam logic [0:0]        c_st_run    = 1'b1;
    localparam logic [AWIDTH-1:0] c_last_addr = '1;
    localparam logic [AWIDTH-1:0] c_one       = AWIDTH'(1);

    logic [0:0]        r_state;
    logic [AWIDTH-1:0] r_clr_cnt;
    logic              r_last_grant;  // 0 = CPU, 1 = IO

    logic w_clearing;
    logic w_grant_cpu;
    logic w_grant_io;

    assign w_clearing = !rst && (r_state == c_st_clear);

    // Zero-latency arbitration; a pending clear command blocks all grants.
    always_comb begin
        w_grant_cpu = 1'b0;
        w_grant_io  = 1'b0;
        if (!rst && (r_state == c_st_run) && !clr_start) begin
            if (cpu_wr_req && io_wr_req) begin
                w_grant_cpu = r_last_grant;
                w_grant_io  = !r_last_grant;
            end else begin
                w_grant_cpu = cpu_wr_req;
                w_grant_io  = io_wr_req;
            end
        end
    end

    always_comb begin
        busy           = w_clearing;
        clr_done       = w_clearing && (r_clr_cnt == c_last_addr);
        cpu_wr_ack     = w_grant_cpu;
        io_wr_ack      = w_grant_io;
        port_c_we      = w_clearing || w_grant_cpu || w_grant_io;
        port_c_address = '0;
        port_c_data    = 1'b0;
        if (w_clearing) begin
            port_c_address = r_clr_cnt;
        end else if (w_grant_cpu) begin
            port_c_address = cpu_wr_addr;
            port_c_data    = cpu_wr_data;
        end else if (w_grant_io) begin
            port_c_address = io_wr_addr;
            port_c_data    = io_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_clear;
            r_clr_cnt    <= '0;
            r_last_grant <= 1'b1;
        end else if (r_state == c_st_clear) begin
            // Counter wraps to zero naturally after the last address.
            r_clr_cnt <= r_clr_cnt + c_one;
            if (r_clr_cnt == c_last_addr) begin
                r_state <= c_st_run;
            end
        end else begin
            if (clr_start) begin
                r_state   <= c_st_clear;
                r_clr_cnt <= '0;
            end else if (w_grant_cpu) begin
                r_last_grant <= 1'b0;
            end else if (w_grant_io) begin
                r_last_grant <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
